// File: rtl/uart_rx_pkg.sv
// Shared definitions for the parametrised UART receiver: FSM encoding and
// elaboration-time helpers for counter sizing.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_t;

  // Tick index of the first (mid start bit) sample after the start edge
  function automatic int unsigned half_bit(input int unsigned oversample);
    return oversample / 2 - 1;
  endfunction

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO; a pop in the same cycle frees room for a push
// into a full FIFO, otherwise a push while full is dropped and flagged.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_din,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_empty,
  output logic [clog2(DEPTH):0]    o_count,
  output logic                     o_overrun
);

  localparam int unsigned AW = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;
  localparam int unsigned CW = clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_pop && !w_empty;
  assign w_push  = i_push && (!w_full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

  assign o_dout    = w_empty ? '0 : r_mem[r_rptr];
  assign o_empty   = w_empty;
  assign o_count   = r_count;
  assign o_overrun = i_push && !w_push;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with show-ahead FIFO and sticky
// framing / parity / overrun error flags.
module uart_rx_param
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned OVERSAMPLE  = 8,
  parameter int unsigned PARITY_EN   = 0,
  parameter int unsigned PARITY_ODD  = 0,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en_rx,
  input  logic                          rxd,
  input  logic                          rd_en,
  input  logic                          err_clr,
  output logic [DATA_BITS-1:0]          d_out,
  output logic                          rx_valid,
  output logic [clog2(FIFO_DEPTH):0]    fifo_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun
);

  localparam int unsigned CNT_W = clog2(OVERSAMPLE);
  localparam int unsigned BIT_W = clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] C_HALF  = CNT_W'(half_bit(OVERSAMPLE));
  localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] C_BLAST = BIT_W'(DATA_BITS - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  rx_state_t              r_state;
  logic [CNT_W-1:0]       r_scnt;
  logic [BIT_W-1:0]       r_bcnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_par_bad;
  logic                   r_frame_err;
  logic                   r_parity_err;
  logic                   r_overrun;

  logic                   w_rs;
  logic                   w_sample_pt;
  logic                   w_par_exp;
  logic                   w_stop_tick;
  logic                   w_push;
  logic                   w_frame_bad;
  logic                   w_fifo_empty;
  logic                   w_fifo_ovr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= '1;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], rxd};
  end

  assign w_rs        = r_sync[SYNC_STAGES-1];
  assign w_sample_pt = (r_state == ST_START) ? (r_scnt == C_HALF) : (r_scnt == C_LAST);
  assign w_par_exp   = (^r_shift) ^ (PARITY_ODD != 0);

  // Push/frame decisions are decoded on the stop sample tick itself so the
  // FIFO writes on that same edge and rx_valid follows one clk later.
  assign w_stop_tick = en_rx && (r_state == ST_STOP) && (r_scnt == C_LAST);
  assign w_push      = w_stop_tick && w_rs;
  assign w_frame_bad = w_stop_tick && !w_rs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_scnt    <= '0;
      r_bcnt    <= '0;
      r_shift   <= '0;
      r_par_bad <= 1'b0;
    end else if (en_rx) begin
      case (r_state)
        ST_IDLE: begin
          if (!w_rs) begin
            r_state   <= ST_START;
            r_scnt    <= '0;
            r_par_bad <= 1'b0;
          end
        end
        ST_START: begin
          if (w_sample_pt) begin
            r_scnt <= '0;
            if (w_rs) begin
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_DATA;
              r_bcnt  <= C_BLAST;
            end
          end else begin
            r_scnt <= r_scnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (w_sample_pt) begin
            r_scnt  <= '0;
            r_shift <= {w_rs, r_shift[DATA_BITS-1:1]};
            if (r_bcnt == '0) r_state <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            else              r_bcnt  <= r_bcnt - BIT_W'(1);
          end else begin
            r_scnt <= r_scnt + CNT_W'(1);
          end
        end
        ST_PARITY: begin
          if (w_sample_pt) begin
            r_scnt    <= '0;
            r_par_bad <= (w_rs != w_par_exp);
            r_state   <= ST_STOP;
          end else begin
            r_scnt <= r_scnt + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (w_sample_pt) begin
            r_scnt  <= '0;
            r_state <= w_rs ? ST_IDLE : ST_WAIT_IDLE;
          end else begin
            r_scnt <= r_scnt + CNT_W'(1);
          end
        end
        ST_WAIT_IDLE: begin
          if (w_rs) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // A new error in the same cycle as err_clr keeps its flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_err  <= (r_frame_err  && !err_clr) || w_frame_bad;
      r_parity_err <= (r_parity_err && !err_clr) || (w_push && r_par_bad);
      r_overrun    <= (r_overrun    && !err_clr) || w_fifo_ovr;
    end
  end

  uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_pop     (rd_en),
    .i_din     (r_shift),
    .o_dout    (d_out),
    .o_empty   (w_fifo_empty),
    .o_count   (fifo_count),
    .o_overrun (w_fifo_ovr)
  );

  assign rx_valid   = !w_fifo_empty;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three instances (8N1 default, 8E1, 5N1) driven by
// directed frames; a monitor pops each presented word against a scoreboard.
module tb_uart_rx_param;

  localparam int unsigned OS = 8;

  logic       clk = 1'b0;
  logic [1:0] r_div = 2'd0;
  logic       en_rx;

  always #5 clk = ~clk;
  always @(posedge clk) r_div <= r_div + 2'd1;
  assign en_rx = (r_div == 2'd3);

  logic rst_v [3];
  logic rxd_v [3];
  logic rd_v  [3];
  logic clr_v [3];
  logic [2:0] auto_rd;

  logic [7:0] a_d, p_d;
  logic [4:0] f_d;
  logic       a_val, p_val, f_val;
  logic [2:0] a_cnt, p_cnt, f_cnt;
  logic       a_fe, p_fe, f_fe, a_pe, p_pe, f_pe, a_ov, p_ov, f_ov;

  logic [7:0] dv  [3];
  logic       val [3];
  assign dv[0] = a_d;  assign dv[1] = p_d;  assign dv[2] = {3'b000, f_d};
  assign val[0] = a_val; assign val[1] = p_val; assign val[2] = f_val;

  uart_rx_param u_a (
    .clk(clk), .rst(rst_v[0]), .en_rx(en_rx), .rxd(rxd_v[0]), .rd_en(rd_v[0]),
    .err_clr(clr_v[0]), .d_out(a_d), .rx_valid(a_val), .fifo_count(a_cnt),
    .frame_err(a_fe), .parity_err(a_pe), .overrun(a_ov));

  uart_rx_param #(.PARITY_EN(1), .PARITY_ODD(0)) u_p (
    .clk(clk), .rst(rst_v[1]), .en_rx(en_rx), .rxd(rxd_v[1]), .rd_en(rd_v[1]),
    .err_clr(clr_v[1]), .d_out(p_d), .rx_valid(p_val), .fifo_count(p_cnt),
    .frame_err(p_fe), .parity_err(p_pe), .overrun(p_ov));

  uart_rx_param #(.DATA_BITS(5)) u_f (
    .clk(clk), .rst(rst_v[2]), .en_rx(en_rx), .rxd(rxd_v[2]), .rd_en(rd_v[2]),
    .err_clr(clr_v[2]), .d_out(f_d), .rx_valid(f_val), .fifo_count(f_cnt),
    .frame_err(f_fe), .parity_err(f_pe), .overrun(f_ov));

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [7:0] q2 [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [7:0] exp_w;
    bit         have;
    for (int i = 0; i < 3; i++) begin
      rd_v[i] = 1'b0;
      if (auto_rd[i] && !rst_v[i] && val[i]) begin
        have  = 1'b0;
        exp_w = '0;
        case (i)
          0: if (q0.size() > 0) begin have = 1'b1; exp_w = q0.pop_front(); end
          1: if (q1.size() > 0) begin have = 1'b1; exp_w = q1.pop_front(); end
          default: if (q2.size() > 0) begin have = 1'b1; exp_w = q2.pop_front(); end
        endcase
        if (!have) chk($sformatf("unexpected_word_inst%0d", i), {24'd0, dv[i]}, 32'hFFFF_FFFF);
        else       chk($sformatf("word_inst%0d", i), {24'd0, dv[i]}, {24'd0, exp_w});
        rd_v[i] = 1'b1;
      end
    end
  end

  // Returns one time unit after the n-th following en_rx edge.
  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk iff en_rx);
      @(posedge clk);
    end
    #1;
  endtask

  task automatic bit_out(input int i, input logic v);
    rxd_v[i] = v;
    wait_ticks(OS);
  endtask

  task automatic send_head(input int i, input logic [7:0] data, input int nbits, input int par);
    bit_out(i, 1'b0);
    for (int b = 0; b < nbits; b++) bit_out(i, data[b]);
    if (par >= 0) bit_out(i, par[0]);
  endtask

  task automatic send(input int i, input logic [7:0] data, input int nbits, input int par, input logic stop);
    send_head(i, data, nbits, par);
    bit_out(i, stop);
    bit_out(i, 1'b1);
  endtask

  task automatic pulse_clr(input int i);
    @(negedge clk); clr_v[i] = 1'b1;
    @(negedge clk); clr_v[i] = 1'b0;
    #1;
  endtask

  task automatic drain();
    int budget;
    budget = 400;
    while ((q0.size() + q1.size() + q2.size()) > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    chk("scoreboard_drained", q0.size() + q1.size() + q2.size(), 0);
  endtask

  initial begin
    auto_rd = 3'b000;
    for (int i = 0; i < 3; i++) begin
      rst_v[i] = 1'b1; rxd_v[i] = 1'b1; clr_v[i] = 1'b0;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("reset_valid", a_val, 0);
    chk("reset_dout",  a_d,   0);
    chk("reset_count", a_cnt, 0);
    chk("reset_flags", {a_fe, a_pe, a_ov, f_fe, f_pe, f_ov}, 0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) rst_v[i] = 1'b0;
    auto_rd = 3'b111;
    wait_ticks(2);

    // 8N1 0xA5, checking push latency around the stop sample tick
    q0.push_back(8'hA5);
    send_head(0, 8'hA5, 8, -1);
    rxd_v[0] = 1'b1;
    wait_ticks(4);
    chk("a5_before_stop_sample", a_val, 0);
    wait_ticks(1);
    chk("a5_valid_after_stop", a_val, 1);
    chk("a5_dout", a_d, 8'hA5);
    chk("a5_count", a_cnt, 1);
    wait_ticks(3);
    chk("a5_popped_valid", a_val, 0);
    chk("a5_popped_dout", a_d, 0);
    chk("a5_no_errors", {a_fe, a_pe, a_ov}, 0);
    bit_out(0, 1'b1);

    // 8E1 0x07 with a wrong parity bit, then a correct 0x03
    q1.push_back(8'h07);
    send(1, 8'h07, 8, 0, 1'b1);
    chk("par_err_set", p_pe, 1);
    chk("par_no_frame_err", p_fe, 0);
    pulse_clr(1);
    chk("par_err_cleared", p_pe, 0);
    q1.push_back(8'h03);
    send(1, 8'h03, 8, 0, 1'b1);
    chk("par_ok_no_err", p_pe, 0);

    // Framing error on 0x3C, recovery with 0x55
    send(0, 8'h3C, 8, -1, 1'b0);
    chk("frame_err_set", a_fe, 1);
    chk("frame_no_push", a_cnt, 0);
    q0.push_back(8'h55);
    send(0, 8'h55, 8, -1, 1'b1);
    chk("frame_err_sticky", a_fe, 1);
    pulse_clr(0);
    chk("frame_err_cleared", a_fe, 0);

    // Start glitch shorter than half a bit
    rxd_v[0] = 1'b0;
    wait_ticks(2);
    rxd_v[0] = 1'b1;
    wait_ticks(2 * OS);
    chk("glitch_no_push", a_cnt, 0);
    chk("glitch_no_flags", {a_fe, a_pe, a_ov}, 0);
    q0.push_back(8'h5A);
    send(0, 8'h5A, 8, -1, 1'b1);

    // Overrun with FIFO_DEPTH=4
    auto_rd[0] = 1'b0;
    for (int w = 1; w <= 5; w++) begin
      if (w <= 4) q0.push_back(8'(w));
      send(0, 8'(w), 8, -1, 1'b1);
    end
    chk("ovr_count_full", a_cnt, 4);
    chk("ovr_flag", a_ov, 1);
    chk("ovr_head", a_d, 8'h01);
    auto_rd[0] = 1'b1;
    drain();
    chk("ovr_sticky_after_drain", a_ov, 1);
    pulse_clr(0);
    chk("ovr_cleared", a_ov, 0);

    // 5N1 0x15, then reset mid-frame and receive 0x0A
    auto_rd[2] = 1'b0;
    send(2, 8'h15, 5, -1, 1'b1);
    chk("w5_dout_before_rst", f_d, 5'h15);
    chk("w5_count_before_rst", f_cnt, 1);
    bit_out(2, 1'b0);
    bit_out(2, 1'b0);
    #3 rst_v[2] = 1'b1;
    #1;
    chk("w5_rst_valid", f_val, 0);
    chk("w5_rst_dout", f_d, 0);
    chk("w5_rst_count", f_cnt, 0);
    chk("w5_rst_flags", {f_fe, f_pe, f_ov}, 0);
    rxd_v[2] = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_v[2] = 1'b0;
    auto_rd[2] = 1'b1;
    wait_ticks(2);
    q2.push_back(8'h0A);
    send(2, 8'h0A, 5, -1, 1'b1);
    chk("w5_after_rst_flags", {f_fe, f_pe, f_ov}, 0);

    drain();
    chk("final_counts", {a_cnt, p_cnt, f_cnt}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receive unit, successor to the fixed 8N1 receiver in the MiniUart IO device. It takes serial data on rxd at an oversampling tick rate. Data width, parity and oversample ratio are configurable. Received words go into an internal show-ahead FIFO, and the block reports sticky framing, parity and overrun errors. It sits between the UART pin synchroniser and the CPU-side bus bridge. It uses a single clock domain with no derived clocks.

Parameters:
DATA_BITS, 8, data bits per frame (5..8), LSB first
OVERSAMPLE, 8, en_rx ticks per bit; even, 4..16
PARITY_EN, 0, 1 = one parity bit follows the data bits
PARITY_ODD, 0, 1 = odd parity, 0 = even (used only if PARITY_EN)
FIFO_DEPTH, 4, receive FIFO entries; power of two, 2..16
SYNC_STAGES, 2, rxd synchroniser flops (2..3)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
en_rx  in  1  oversample tick, one clk wide, OVERSAMPLE per bit period
rxd  in  1  serial input, asynchronous, idle high
rd_en  in  1  pop the FIFO head (ignored when empty)
err_clr  in  1  synchronous clear of all sticky error flags
d_out  out  DATA_BITS  FIFO head word (show-ahead), zeros when empty
rx_valid  out  1  FIFO non-empty
fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
frame_err  out  1  sticky: stop bit sampled low
parity_err  out  1  sticky: parity mismatch
overrun  out  1  sticky: word completed while FIFO full

Behaviour:
- Reset: FSM=IDLE. Counters, FIFO pointers and count are 0. All outputs are 0. The synchroniser flops reset to 1.
- rxd passes through SYNC_STAGES flops. All uses below refer to the synchronised value rs.
- FSM and counters advance only on clk cycles with en_rx=1. The FIFO and error flags update on every clk.
- Sample point: the sample counter reaches OVERSAMPLE/2-1 after loading. After the first sample it reloads every OVERSAMPLE ticks.
- FSM states:
  - IDLE: rs=0 on a tick goes to START and loads the sample counter.
  - START: at the sample point, rs=1 is a glitch and returns to IDLE with no push. rs=0 goes to DATA with bit counter = DATA_BITS-1.
  - DATA: at each sample, shift rs into the MSB of the shift register. After DATA_BITS samples, go to PARITY if PARITY_EN, else STOP.
  - PARITY: sample and compare against the XOR of the data (inverted if PARITY_ODD). Latch the mismatch, then go to STOP.
  - STOP: rs=1 pushes the word and returns to IDLE. rs=0 sets frame_err, discards the word (no push) and goes to WAIT_IDLE.
  - WAIT_IDLE: on a tick with rs=1, go to IDLE.
- A word with a parity mismatch is still pushed. parity_err is set in the same cycle as the push.
- Push happens on the clk edge following the STOP sample tick, so rx_valid rises 1 clk after that tick.
- FIFO:
  - Push when full: the word is dropped and overrun is set. If rd_en=1 in the same cycle while full, the pop is applied first and the push is accepted; overrun is not set.
  - rd_en while empty is ignored; count stays 0.
  - Simultaneous push and pop while non-empty leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Error flags stay set until err_clr. If err_clr and a new error occur in the same cycle, the new error wins (flag stays 1).
- Reset mid-frame aborts the frame, empties the FIFO and clears the flags. The next frame needs a fresh start edge.

Decomposition:
- uart_rx_pkg: FSM state encoding (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE), the half-bit constant function and the clog2 helper.
- Sub-module uart_rx_fifo: parametrised show-ahead FIFO with push, pop, full, empty, count and an overrun pulse. The top instantiates it once.

Test Plan:
1. Defaults, send 0xA5 with a correct stop bit → 1 clk after the stop sample tick, rx_valid=1, d_out=8'hA5, fifo_count=1, no errors. rd_en → rx_valid=0, d_out=0.
2. PARITY_EN=1, PARITY_ODD=0, send 0x07 with parity bit 0 (wrong) → 0x07 pushed, parity_err=1. err_clr → 0.
3. Send 0x3C with the stop bit low, then idle high → no push, frame_err=1. A following 0x55 is received correctly.
4. FIFO_DEPTH=4: send 5 words (0x01..0x05) with no reads → fifo_count=4, overrun=1. Reads return 0x01..0x04 in order.
5. rxd low pulse of 2 ticks (shorter than half a bit) → FSM returns to IDLE, no push, no error flags.
6. DATA_BITS=5: send 0x15, then assert rst mid-frame of a second word → d_out=5'h15 before the reset. After reset, all outputs are 0 and the next frame 0x0A is received intact.
